multiplier_fixed_point_seq: RTL and testbench

- Iterative shift-add fixed-point multiplier: computes a * b with a in A1.A2 format and b in B1.B2 format.
- Result is returned in A1.A2 format, truncated toward zero and saturated on overflow.
- Inverse-direction companion to the iterative fixed-point divider. Shares its operand/format conventions so datapaths can scale by a constant and undo it.
- Fixed latency; valid/ready handshake on both sides.

---
 rtl/fixed_point_pkg.sv | 34 +++
 rtl/fixed_point_mul_finalize.sv | 64 ++++++
 rtl/multiplier_fixed_point_seq.sv | 125 ++++++++++++
 tb/tb_multiplier_fixed_point_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the iterative fixed-point multiplier and divider:
// the sequencer state encoding and the saturation constants.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest positive value of a width-bit number, zero-extended to 64 bits.
    // The caller keeps the low `width` bits.
    function automatic logic [63:0] fixedMaxPos(input int width, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed) begin
            return (one << (width - 1)) - one;
        end
        return (one << width) - one;
    endfunction

    // Most negative value of a width-bit number as a raw bit pattern (0x80..0).
    // It is zero for unsigned formats.
    function automatic logic [63:0] fixedMinNeg(input int width, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed) begin
            return one << (width - 1);
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/fixed_point_mul_finalize.sv
// Result stage of the shift-add multiplier. It drops the B2 fraction bits
// of the raw magnitude product, applies the sign and saturates to A1.A2.
// It is purely combinational, so it can be tested on its own.
module fixed_point_mul_finalize
    import fixed_point_pkg::*;
#(
    parameter int A1     = 8,
    parameter int A2     = 8,
    parameter int B1     = 8,
    parameter int B2     = 8,
    parameter int SIGNED = 1
) (
    input  logic [A1+A2+B1+B2-1:0] acc,
    input  logic                   neg,
    output logic [A1+A2-1:0]       result,
    output logic                   overflow
);

    localparam int AW   = A1 + A2;
    localparam int ACCW = A1 + A2 + B1 + B2;
    localparam int MW   = ACCW - B2;

    localparam logic [63:0] MAX_POS_64 = fixedMaxPos(AW, SIGNED != 0);
    localparam logic [63:0] MIN_NEG_64 = fixedMinNeg(AW, SIGNED != 0);

    localparam logic [AW-1:0] MAX_POS = MAX_POS_64[AW-1:0];
    localparam logic [AW-1:0] MIN_NEG = MIN_NEG_64[AW-1:0];

    // A magnitude above these limits cannot be represented in A1.A2.
    // In unsigned mode LIM_POS is all ones, so "above" means >= 2^AW.
    localparam logic [MW-1:0] LIM_POS = MW'(MAX_POS_64);
    localparam logic [MW-1:0] LIM_NEG = MW'(MIN_NEG_64);

    logic [MW-1:0] mag;
    logic          unused_frac;

    // Truncating the magnitude before applying the sign rounds toward zero.
    assign mag         = acc[ACCW-1:B2];
    assign unused_frac = ^acc[B2-1:0];

    // Apply the sign, then clamp to the format range.
    always_comb begin
        // NOTE: give every output a default first so that no path through the ifs infers a latch.
        result   = '0;
        overflow = 1'b0;
        if (neg) begin
            if (mag > LIM_NEG) begin
                result   = MIN_NEG;
                overflow = 1'b1;
            end else begin
                // A zero magnitude negates to zero, so -0 never appears.
                result = -mag[AW-1:0];
            end
        end else begin
            if (mag > LIM_POS) begin
                result   = MAX_POS;
                overflow = 1'b1;
            end else begin
                result = mag[AW-1:0];
            end
        end
    end

endmodule

// File: rtl/multiplier_fixed_point_seq.sv
// Iterative shift-add fixed-point multiplier: out = a * b. The operand a is
// in A1.A2 format, b is in B1.B2 format and out is in A1.A2 format.
// It handles one multiplier bit per clock, LSB first, with a fixed latency.
// It has a valid/ready handshake on both the operand and the result side.
module multiplier_fixed_point_seq
    import fixed_point_pkg::*;
#(
    parameter int A1     = 8,
    parameter int A2     = 8,
    parameter int B1     = 8,
    parameter int B2     = 8,
    parameter int SIGNED = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [A1+A2-1:0]   a,
    input  logic [B1+B2-1:0]   b,
    output logic               outValid,
    input  logic               outReady,
    output logic [A1+A2-1:0]   out,
    output logic               overflow
);

    localparam int AW   = A1 + A2;
    localparam int W    = B1 + B2;
    localparam int ACCW = W + AW;
    localparam int CW   = ($clog2(W) > 0) ? $clog2(W) : 1;

    state_t          state;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] mcand;
    logic [W-1:0]    mplier;
    logic [CW-1:0]   count;
    logic            neg;

    logic [AW-1:0]   abs_a;
    logic [W-1:0]    abs_b;
    logic            neg_in;

    logic [AW-1:0]   fin_out;
    logic            fin_ovf;

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);

    // Split each operand into a magnitude and a sign. Negating the most
    // negative value gives 2^(n-1), which still fits as an unsigned number.
    always_comb begin
        abs_a  = a;
        abs_b  = b;
        neg_in = 1'b0;
        if (SIGNED != 0) begin
            if (a[AW-1]) abs_a = -a;
            if (b[W-1])  abs_b = -b;
            neg_in = a[AW-1] ^ b[W-1];
        end
    end

    fixed_point_mul_finalize #(
        .A1     (A1),
        .A2     (A2),
        .B1     (B1),
        .B2     (B2),
        .SIGNED (SIGNED)
    ) u_finalize (
        .acc      (acc),
        .neg      (neg),
        .result   (fin_out),
        .overflow (fin_ovf)
    );

    // Sequencer and datapath: accept, W add/shift steps, finalize, hold result.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the datapath registers are reset too; out must read 0 after reset and nothing stale may survive.
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            neg      <= 1'b0;
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        // NOTE: non-blocking assignments keep every register update in this edge independent of statement order.
                        mcand  <= {{W{1'b0}}, abs_a};
                        mplier <= abs_b;
                        acc    <= '0;
                        count  <= '0;
                        neg    <= neg_in;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(W - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    out      <= fin_out;
                    overflow <= fin_ovf;
                    state    <= DONE;
                end
                DONE: begin
                    if (outReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_fixed_point_seq.sv
// Directed bench for multiplier_fixed_point_seq. It uses two instances, one
// unsigned (sel=0) and one signed (sel=1), both in 8.8 x 8.8 format.
module tb_multiplier_fixed_point_seq;

    // Accept edge k -> outValid first seen after edge k+W+1, with W=16.
    localparam int LAT = 17;

    logic        clock;
    logic        reset;

    logic        u_inValid, u_inReady, u_outValid, u_outReady, u_overflow;
    logic [15:0] u_a, u_b, u_out;
    logic        s_inValid, s_inReady, s_outValid, s_outReady, s_overflow;
    logic [15:0] s_a, s_b, s_out;

    int errors;
    int checks;

    multiplier_fixed_point_seq #(.A1(8), .A2(8), .B1(8), .B2(8), .SIGNED(0)) dut_u (
        .clock(clock), .reset(reset),
        .inValid(u_inValid), .inReady(u_inReady), .a(u_a), .b(u_b),
        .outValid(u_outValid), .outReady(u_outReady),
        .out(u_out), .overflow(u_overflow)
    );

    multiplier_fixed_point_seq #(.A1(8), .A2(8), .B1(8), .B2(8), .SIGNED(1)) dut_s (
        .clock(clock), .reset(reset),
        .inValid(s_inValid), .inReady(s_inReady), .a(s_a), .b(s_b),
        .outValid(s_outValid), .outReady(s_outReady),
        .out(s_out), .overflow(s_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? s_inReady : u_inReady;
    endfunction
    function automatic logic vld(input bit sel);
        return sel ? s_outValid : u_outValid;
    endfunction
    function automatic logic [15:0] res(input bit sel);
        return sel ? s_out : u_out;
    endfunction
    function automatic logic ovf(input bit sel);
        return sel ? s_overflow : u_overflow;
    endfunction

    task automatic set_in(input bit sel, input logic [15:0] av, input logic [15:0] bv, input logic v);
        if (sel) begin s_a = av; s_b = bv; s_inValid = v; end
        else     begin u_a = av; u_b = bv; u_inValid = v; end
    endtask

    task automatic set_rdy(input bit sel, input logic r);
        if (sel) s_outReady = r;
        else     u_outReady = r;
    endtask

    // One transaction; `hold` cycles of backpressure with a competing inValid.
    task automatic do_op(input bit sel, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] exp_o, input logic exp_v,
                         input string tag, input int hold);
        int  cyc;
        bit  seen;
        check({tag, "_inReady_idle"}, 32'(rdy(sel)), 32'd1);
        set_in(sel, av, bv, 1'b1);
        @(posedge clock); #1;
        // Operands changing after the accept edge must not matter.
        set_in(sel, 16'h1234, 16'h5678, 1'b0);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (vld(sel)) seen = 1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check({tag, "_out"}, 32'(res(sel)), 32'(exp_o));
        check({tag, "_ovf"}, 32'(ovf(sel)), 32'(exp_v));
        for (int i = 0; i < hold; i++) begin
            set_in(sel, 16'h0100, 16'h0100, 1'b1);
            @(posedge clock); #1;
            check({tag, "_hold_valid"}, 32'(vld(sel)), 32'd1);
            check({tag, "_hold_inReady"}, 32'(rdy(sel)), 32'd0);
            check({tag, "_hold_out"}, 32'(res(sel)), 32'(exp_o));
            check({tag, "_hold_ovf"}, 32'(ovf(sel)), 32'(exp_v));
        end
        set_in(sel, 16'h0000, 16'h0000, 1'b0);
        set_rdy(sel, 1'b1);
        @(posedge clock); #1;
        set_rdy(sel, 1'b0);
        check({tag, "_inReady_after"}, 32'(rdy(sel)), 32'd1);
        check({tag, "_valid_after"}, 32'(vld(sel)), 32'd0);
    endtask

    initial begin
        int stale;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        set_in(0, 16'h0, 16'h0, 1'b0);
        set_in(1, 16'h0, 16'h0, 1'b0);
        set_rdy(0, 1'b0);
        set_rdy(1, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_inReady", 32'(rdy(s[0])), 32'd1);
            check("rst_outValid", 32'(vld(s[0])), 32'd0);
            check("rst_out", 32'(res(s[0])), 32'd0);
            check("rst_ovf", 32'(ovf(s[0])), 32'd0);
        end
        reset = 1'b0;

        // Unsigned: 5.75 * 2.125 = 12.21875
        do_op(0, 16'h05C0, 16'h0220, 16'h0C38, 1'b0, "u_basic", 0);
        // Unsigned: 100 * 4 overflows
        do_op(0, 16'h6400, 16'h0400, 16'hFFFF, 1'b1, "u_ovf", 0);
        // Unsigned: largest value * 1.0 is exactly representable
        do_op(0, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b0, "u_edge", 0);
        // Signed: -3.5 * 2.0 = -7.0
        do_op(1, 16'hFC80, 16'h0200, 16'hF900, 1'b0, "s_neg", 0);
        // Signed: -1/256 * 0.5 truncates toward zero
        do_op(1, 16'hFFFF, 16'h0080, 16'h0000, 1'b0, "s_trunc0", 0);
        // Signed: -128 * -1 saturates positive
        do_op(1, 16'h8000, 16'hFF00, 16'h7FFF, 1'b1, "s_satpos", 0);
        // Signed: -128 * 1 is exactly the minimum
        do_op(1, 16'h8000, 16'h0100, 16'h8000, 1'b0, "s_minneg", 0);
        // Signed: -128 * 1.00390625 saturates negative
        do_op(1, 16'h8000, 16'h0101, 16'h8000, 1'b1, "s_satneg", 0);
        // Signed: -0.5 * -0.5 = 0.25
        do_op(1, 16'hFF80, 16'hFF80, 16'h0040, 1'b0, "s_negneg", 0);
        // Signed: max positive * 1.0, no overflow
        do_op(1, 16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, "s_maxpos", 0);

        // Backpressure for 5 cycles, then a second pair goes straight in.
        do_op(1, 16'h0300, 16'hFE00, 16'hFA00, 1'b0, "bp_first", 5);
        do_op(1, 16'h0280, 16'h0180, 16'h03C0, 1'b0, "bp_second", 0);

        // Reset 4 cycles after accept; the in-flight result must vanish.
        set_in(0, 16'h0200, 16'h0300, 1'b1);
        @(posedge clock); #1;
        set_in(0, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mrst_inReady", 32'(u_inReady), 32'd1);
        check("mrst_outValid", 32'(u_outValid), 32'd0);
        check("mrst_out", 32'(u_out), 32'd0);
        stale = 0;
        repeat (25) begin
            @(posedge clock); #1;
            if (u_outValid) stale++;
        end
        check("mrst_no_stale", 32'(stale), 32'd0);
        // 2.5 * 6.0 = 15.0
        do_op(0, 16'h0280, 16'h0600, 16'h0F00, 1'b0, "mrst_next", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
